// File: rtl/aes_round_key_store_if.sv
// Round-key store bus: key-expansion capture side, status, and replay stream.
// The slave modport is the key store; the master modport is its environment.
interface aes_round_key_store_if #(
  parameter int KW   = 128,
  parameter int IDXW = 4
);
  logic            key_load;
  logic [KW-1:0]   rk_in;
  logic            rk_valid;
  logic            keys_ready;
  logic [IDXW-1:0] rk_count;
  logic            err_overflow;
  logic            rd_start;
  logic            rd_dir;
  logic [KW-1:0]   rk_out;
  logic [IDXW-1:0] rk_out_idx;
  logic            rk_out_valid;
  logic            rk_out_ready;
  logic            rk_out_last;

  modport master (
    output key_load, rk_in, rk_valid, rd_start, rd_dir, rk_out_ready,
    input  keys_ready, rk_count, err_overflow,
    input  rk_out, rk_out_idx, rk_out_valid, rk_out_last
  );

  modport slave (
    input  key_load, rk_in, rk_valid, rd_start, rd_dir, rk_out_ready,
    output keys_ready, rk_count, err_overflow,
    output rk_out, rk_out_idx, rk_out_valid, rk_out_last
  );
endinterface

// File: rtl/aes_round_key_store.sv
// AES-256 round-key buffer: captures the expanded key schedule and replays it
// to the cipher core in forward (encrypt) or reverse (decrypt) order.
//
// state     | meaning
// EMPTY     | no schedule armed since reset
// FILLING   | capturing round keys from key expansion
// READY     | all keys stored, waiting for rd_start
// STREAMING | replay pass in progress
module aes_round_key_store #(
  parameter int NUM_RK = 15,
  parameter int KW     = 128,
  parameter int IDXW   = 4
) (
  input logic                  clk,
  input logic                  rst,
  aes_round_key_store_if.slave bus
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_RK - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, READY, STREAMING} state_t;

  state_t          state;
  logic [KW-1:0]   mem [NUM_RK];
  logic [IDXW-1:0] wr_ptr;
  logic            dir_q;
  logic            keys_ready_q;
  logic            err_q;
  logic [KW-1:0]   rk_out_q;
  logic [IDXW-1:0] idx_q;
  logic            valid_q;
  logic            last_q;
  logic [IDXW-1:0] nxt_idx;
  logic            wr_en;
  logic [IDXW-1:0] first_idx;

  assign bus.keys_ready   = keys_ready_q;
  assign bus.rk_count     = wr_ptr;
  assign bus.err_overflow = err_q;
  assign bus.rk_out       = rk_out_q;
  assign bus.rk_out_idx   = idx_q;
  assign bus.rk_out_valid = valid_q;
  assign bus.rk_out_last  = last_q;

  // Next replay index and capture enable (key_load discards a coincident beat).
  always_comb begin
    nxt_idx   = dir_q ? idx_q - IDXW'(1) : idx_q + IDXW'(1);
    first_idx = bus.rd_dir ? LAST_IDX : '0;
    wr_en     = !rst && !bus.key_load && (state == FILLING) && bus.rk_valid;
  end

  // Key storage: contents are not reset, only the write pointer is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.rk_in;
  end

  // Control FSM with registered status and stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      wr_ptr       <= '0;
      dir_q        <= 1'b0;
      keys_ready_q <= 1'b0;
      err_q        <= 1'b0;
      rk_out_q     <= '0;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else if (bus.key_load) begin
      state        <= FILLING;
      wr_ptr       <= '0;
      keys_ready_q <= 1'b0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      if (bus.rk_valid && state != FILLING) err_q <= 1'b1;
      case (state)
        FILLING: begin
          if (bus.rk_valid) begin
            wr_ptr <= wr_ptr + IDXW'(1);
            if (wr_ptr == LAST_IDX) begin
              state        <= READY;
              keys_ready_q <= 1'b1;
            end
          end
        end
        READY: begin
          if (bus.rd_start) begin
            state    <= STREAMING;
            dir_q    <= bus.rd_dir;
            valid_q  <= 1'b1;
            idx_q    <= first_idx;
            rk_out_q <= mem[first_idx];
            last_q   <= (NUM_RK == 1);
          end
        end
        STREAMING: begin
          if (bus.rk_out_ready) begin
            if (last_q) begin
              state   <= READY;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              idx_q    <= nxt_idx;
              rk_out_q <= mem[nxt_idx];
              last_q   <= dir_q ? (nxt_idx == '0) : (nxt_idx == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Round-key buffer between the AES-256 key expansion and the AES cipher round datapath.
- Captures the 15 128-bit round keys streamed out of key expansion and holds them in a register file.
- Replays the keys to the cipher core through a valid/ready stream, one key per beat.
- Replay order is forward (encryption, key 0..14) or reverse (decryption, key 14..0), selectable per pass.

Parameters:
- NUM_RK, 15, number of round keys stored (AES-256: 14 rounds + initial key).
- KW, 128, round-key width in bits.
- IDXW, 4, width of slot index and count; must satisfy 2^IDXW > NUM_RK.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_load  input  1  pulse; discards stored keys and arms capture of a new key schedule.
- rk_in  input  KW  round key from key expansion.
- rk_valid  input  1  rk_in valid this cycle; no backpressure toward key expansion.
- keys_ready  output  1  all NUM_RK keys stored.
- rk_count  output  IDXW  number of slots written since last key_load.
- err_overflow  output  1  sticky; rk_valid seen while not capturing.
- rd_start  input  1  pulse; begin one replay pass.
- rd_dir  input  1  sampled with rd_start: 0 = forward, 1 = reverse.
- rk_out  output  KW  replayed round key.
- rk_out_idx  output  IDXW  slot index of rk_out.
- rk_out_valid  output  1  rk_out valid.
- rk_out_ready  input  1  consumer accepts the beat.
- rk_out_last  output  1  final beat of the pass.

Behaviour:
- States: EMPTY, FILLING, READY, STREAMING. All outputs are registered.
- Reset: state EMPTY; all outputs 0 (keys_ready, rk_count, err_overflow, rk_out, rk_out_idx, rk_out_valid, rk_out_last).
- Reset: write pointer 0. Register-file contents are don't-care.
- Reset mid-operation: abort immediately; same values as above on the next cycle.

key_load (highest priority after rst, accepted in any state):
- Next cycle: state FILLING, rk_count 0, keys_ready 0, err_overflow 0, rk_out_valid 0, rk_out_last 0.
- Any in-flight replay is aborted without a last beat.
- rk_valid in the same cycle as key_load is discarded.

FILLING:
- Each rk_valid=1 writes rk_in to slot rk_count; rk_count increments.
- The write to slot NUM_RK-1 moves to READY. keys_ready=1 and rk_count=NUM_RK from the next cycle.
- Gaps in rk_valid are allowed and have no effect.

Overflow:
- rk_valid=1 in EMPTY, READY or STREAMING is ignored (no write) and sets err_overflow=1 on the next cycle.
- err_overflow holds until key_load or rst.

READY:
- rd_start=1 latches rd_dir. Next cycle: state STREAMING, rk_out_valid=1.
- First beat: rk_out_idx = 0 (forward) or NUM_RK-1 (reverse); rk_out = slot[rk_out_idx].
- rd_start in EMPTY or FILLING is ignored.

STREAMING:
- Beat transfers when rk_out_valid && rk_out_ready.
- On transfer, the next cycle presents the next index (+1 forward, -1 reverse).
- rk_out, rk_out_idx and rk_out_last are held stable while valid && !ready.
- rk_out_last=1 exactly when rk_out_idx = NUM_RK-1 (forward) or 0 (reverse).
- Transfer of the last beat: next cycle rk_out_valid=0, rk_out_last=0, state READY.
- rd_start during STREAMING is ignored. rd_start in the same cycle as the last transfer is also ignored; a new pass needs rd_start in READY.
- Latency: rd_start at cycle t gives the first valid at t+1. With ready held high, 15 beats occupy t+1..t+15 and valid drops at t+16.
- Stored keys persist across passes; unlimited replays per key_load.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> every output 0, state EMPTY. rk_valid afterwards sets err_overflow=1.
- Fill: key_load, then 15 rk_valid beats with rk_in = {32{i[3:0]}}, i=0..14, including one idle gap. keys_ready rises the cycle after the 15th write; rk_count=15.
- Forward replay: rd_start with rd_dir=0, rk_out_ready=1 -> 15 consecutive beats with idx 0..14 and matching data, last only on idx 14. valid low on the 16th cycle after rd_start.
- Reverse replay with backpressure: rd_dir=1, ready toggling 1,0,0,1,... -> idx 14..0 in order, data/idx stable during stalls, no beat lost or duplicated, last on idx 0.
- Abort: key_load while rk_out_idx=5 is stalled -> next cycle valid=0, keys_ready=0, rk_count=0. A new 15-key fill then replays only the new keys.
- Collisions: key_load together with rk_valid -> beat discarded, rk_count=0. A 16th rk_valid after the fill -> err_overflow=1, slot 14 unchanged on replay.
